lsu: RTL and testbench
======================

# lsu

Load/store unit sitting directly downstream of the EX stage's address generation: it takes the EX-computed effective address, store data and memory opcode, drives the data-bus handshake, and returns formatted load data to the MEM/WB path. It generates byte enables and misalignment exceptions, and stalls the pipeline while a bus transaction is pending. At most one transaction is outstanding at any time.

## Interface
Parameters:
- none. Data and address widths are fixed at 32 bits, matching `DATA_RANGE`.

Ports:
- clk  in  1  core clock; one clock domain. Already decided.
- rst  in  1  synchronous, active-high reset. Already decided.
- ex_mem_rd_op  in  3  load op: 000 NOP, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; other codes are treated as NOP.
- ex_mem_wr_op  in  2  store op: 00 NOP, 01 SB, 10 SH, 11 SW.
- ex_addr  in  32  effective address (EX lsu_addr).
- ex_wdata  in  32  store data (EX lsu_wdata).
- flush  in  1  kill the current EX instruction and any in-flight load result.
- dbus_req  out  1  bus request.
- dbus_we  out  1  1 = write.
- dbus_addr  out  32  word-aligned address ({ex_addr[31:2],2'b00}).
- dbus_wdata  out  32  lane-replicated store data.
- dbus_be  out  4  byte enables.
- dbus_ready  in  1  slave accepts the request this cycle.
- dbus_rvalid  in  1  read data valid.
- dbus_rdata  in  32  read data.
- lsu_mem_rd  out  1  a load was accepted this cycle (feeds ex2mem_mem_rd).
- lsu_stall  out  1  hold IF/ID/EX this cycle.
- lsu_rdata  out  32  formatted load data.
- lsu_rdata_valid  out  1  lsu_rdata is valid this cycle.
- exc_load_misaligned  out  1  single-cycle exception pulse.
- exc_store_misaligned  out  1  single-cycle exception pulse.
- exc_addr  out  32  faulting address; valid with either exception pulse.

## Operation
- Op selection:
  - A store takes priority if both ops are nonzero.
  - The active op is considered only when the state allows issue and `flush`=0.
- Misalignment (checked before issue):
  - LH/LHU/SH fault when addr[0]=1.
  - LW/SW fault when addr[1:0]≠0.
  - On a fault: no `dbus_req`; the matching exc_* output is 1 combinationally with exc_addr=ex_addr; no stall.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}.
  - SW: be=4'hF, wdata unchanged.
- Loads: be=4'hF.
- State machine (registered):
  - IDLE:
    - Valid aligned op: dbus_req=1.
    - If !dbus_ready: lsu_stall=1 and stay; EX is held, so the inputs stay stable.
    - Accepted store: stay in IDLE.
    - Accepted load: lsu_mem_rd=1; latch op and addr[1:0]; go to RD_WAIT.
  - RD_WAIT:
    - !dbus_rvalid: lsu_stall=1; no new request is issued.
    - dbus_rvalid: lsu_rdata_valid=1. The state then behaves as IDLE in the same cycle, so a back-to-back request may issue; go to RD_WAIT if that new load is accepted, else IDLE.
    - flush=1 with !dbus_rvalid: go to DRAIN.
    - flush=1 coincident with dbus_rvalid: suppress rdata_valid; go to IDLE; no issue that cycle.
  - DRAIN:
    - lsu_stall=1; no issue.
    - dbus_rvalid is consumed with lsu_rdata_valid=0, then go to IDLE.
- Load formatting:
  - Select the byte or half at the latched offset from dbus_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - lsu_rdata is combinational from dbus_rdata and is 0 when not valid.
- flush in IDLE: no request and no exception, even if the op is present.

## Timing
- Reset: state=IDLE, latched op/offset=0.
- All outputs are 0 during and immediately after reset; this includes dbus_req, lsu_stall, lsu_mem_rd, lsu_rdata_valid, both exceptions and exc_addr.
- A reset asserted in RD_WAIT or DRAIN abandons the transaction; any late rvalid after reset is ignored in IDLE.
- Store latency is 1 cycle with a zero-wait slave (no stall); each !dbus_ready cycle adds one stall cycle.
- Load: request in cycle N; earliest rvalid/rdata_valid in N+1; stall covers N+1.. until rvalid.
- dbus_* outputs and exceptions are combinational from EX inputs and state; the next state is registered.
- dbus_rvalid in IDLE (unsolicited) is ignored.

## Test plan
- Store mix:
  - SB addr=0x1003, wdata=0x000000AB, ready=1 → req=1, we=1, addr=0x1000, be=4'b1000, wdata=0xABABABAB, no stall.
  - SH addr=0x1002, wdata=0x1234 → be=4'b1100, wdata=0x12341234.
- Load formatting, rdata=0x80F17F01:
  - LB @+3 → 0xFFFFFF80.
  - LBU @+3 → 0x00000080.
  - LH @+2 → 0xFFFF80F1.
  - LHU @+0 → 0x00007F01.
  - LW → 0x80F17F01.
  - Each with rvalid one cycle after acceptance and stall=1 for exactly that cycle.
- Wait states:
  - Load with ready low for 2 cycles, then rvalid 3 cycles after acceptance → stall=1 for 5 consecutive cycles.
  - lsu_mem_rd=1 only in the acceptance cycle.
- Misaligned:
  - LW addr=0x2002 → exc_load_misaligned=1, exc_addr=0x2002, dbus_req=0, no stall.
  - SH addr=0x2001 → exc_store_misaligned=1.
- Flush:
  - Load accepted, flush next cycle with rvalid 2 cycles later → DRAIN, stall held until rvalid, lsu_rdata_valid never 1, then IDLE.
- Back-to-back:
  - LW then SW at 0x3000, rvalid arrives in the cycle the SW is presented → rdata_valid=1 and the SW req issued that same cycle.
- Reset:
  - Reset asserted in RD_WAIT → next cycle IDLE with all outputs 0.

Source files
------------

// File: rtl/lsu_if.sv
// Data-bus bundle between the load/store unit (master) and the memory slave.
interface lsu_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ready;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    input  dbus_ready, dbus_rvalid, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    output dbus_ready, dbus_rvalid, dbus_rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: issues one data-bus transaction at a time from the EX
// stage, builds byte lanes, flags misaligned accesses and formats load data.
// Bus outputs and exceptions are combinational; only the state is registered.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ex_mem_rd_op,
  input  logic [1:0]  ex_mem_wr_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic        flush,
  lsu_if.master       dbus,
  output logic        lsu_mem_rd,
  output logic        lsu_stall,
  output logic [31:0] lsu_rdata,
  output logic        lsu_rdata_valid,
  output logic        exc_load_misaligned,
  output logic        exc_store_misaligned,
  output logic [31:0] exc_addr
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [2:0]  ld_op_r;
  logic [1:0]  ld_off_r;

  logic        is_store_s;
  logic        is_load_s;
  logic        misalign_s;
  logic        issue_ok_s;
  logic        rdata_valid_s;
  logic        stall_wait_s;
  logic        req_s;
  logic        fault_s;
  logic        accept_ld_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] shifted_s;

  // Decode the EX op (store wins) and check natural alignment of its size.
  always_comb begin
    is_store_s = (ex_mem_wr_op != 2'd0);
    is_load_s  = 1'b0;
    misalign_s = 1'b0;
    case (ex_mem_rd_op)
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5: is_load_s = 1'b1;
      default:                      is_load_s = 1'b0;
    endcase
    if (is_store_s) begin
      case (ex_mem_wr_op)
        2'd2:    misalign_s = ex_addr[0];
        2'd3:    misalign_s = |ex_addr[1:0];
        default: misalign_s = 1'b0;
      endcase
    end else begin
      case (ex_mem_rd_op)
        3'd2, 3'd5: misalign_s = ex_addr[0];
        3'd3:       misalign_s = |ex_addr[1:0];
        default:    misalign_s = 1'b0;
      endcase
    end
  end

  // Next-state logic and handshake control; a returning load frees the slot
  // in the same cycle so a following op can issue back-to-back.
  always_comb begin
    state_nxt_s   = state_r;
    issue_ok_s    = 1'b0;
    rdata_valid_s = 1'b0;
    stall_wait_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        issue_ok_s = ~flush & ~rst;
      end
      ST_RD_WAIT: begin
        if (dbus.dbus_rvalid) begin
          issue_ok_s    = ~flush & ~rst;
          rdata_valid_s = ~flush & ~rst;
          state_nxt_s   = ST_IDLE;
        end else begin
          stall_wait_s = ~rst;
          state_nxt_s  = flush ? ST_DRAIN : ST_RD_WAIT;
        end
      end
      ST_DRAIN: begin
        stall_wait_s = ~rst;
        state_nxt_s  = dbus.dbus_rvalid ? ST_IDLE : ST_DRAIN;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    req_s       = issue_ok_s & (is_store_s | is_load_s) & ~misalign_s;
    fault_s     = issue_ok_s & (is_store_s | is_load_s) & misalign_s;
    accept_ld_s = req_s & ~is_store_s & dbus.dbus_ready;
    if (accept_ld_s) begin
      state_nxt_s = ST_RD_WAIT;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Byte-lane enables and lane-replicated store data.
  always_comb begin
    be_s    = 4'hF;
    wdata_s = 32'd0;
    if (is_store_s) begin
      case (ex_mem_wr_op)
        2'd1: begin
          be_s    = 4'b0001 << ex_addr[1:0];
          wdata_s = {4{ex_wdata[7:0]}};
        end
        2'd2: begin
          be_s    = 4'b0011 << ex_addr[1:0];
          wdata_s = {2{ex_wdata[15:0]}};
        end
        default: begin
          be_s    = 4'hF;
          wdata_s = ex_wdata;
        end
      endcase
    end else begin
      be_s    = 4'hF;
      wdata_s = 32'd0;
    end
  end

  // Drive the bus and pipeline-facing control outputs.
  always_comb begin
    dbus.dbus_req        = req_s;
    dbus.dbus_we         = req_s & is_store_s;
    dbus.dbus_addr       = req_s ? {ex_addr[31:2], 2'b00} : 32'd0;
    dbus.dbus_be         = req_s ? be_s : 4'd0;
    dbus.dbus_wdata      = (req_s & is_store_s) ? wdata_s : 32'd0;
    lsu_mem_rd           = accept_ld_s;
    lsu_stall            = stall_wait_s | (req_s & ~dbus.dbus_ready);
    lsu_rdata_valid      = rdata_valid_s;
    exc_load_misaligned  = fault_s & ~is_store_s;
    exc_store_misaligned = fault_s & is_store_s;
    exc_addr             = fault_s ? ex_addr : 32'd0;
  end

  // Pick the addressed byte/half of the returned word and extend it.
  always_comb begin
    shifted_s = dbus.dbus_rdata >> {ld_off_r, 3'b000};
    lsu_rdata = 32'd0;
    if (rdata_valid_s) begin
      case (ld_op_r)
        3'd1:    lsu_rdata = {{24{shifted_s[7]}}, shifted_s[7:0]};
        3'd2:    lsu_rdata = {{16{shifted_s[15]}}, shifted_s[15:0]};
        3'd3:    lsu_rdata = dbus.dbus_rdata;
        3'd4:    lsu_rdata = {24'd0, shifted_s[7:0]};
        3'd5:    lsu_rdata = {16'd0, shifted_s[15:0]};
        default: lsu_rdata = 32'd0;
      endcase
    end else begin
      lsu_rdata = 32'd0;
    end
  end

  // State register plus the op/offset of the load currently in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      ld_op_r  <= 3'd0;
      ld_off_r <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_ld_s) begin
        ld_op_r  <= ex_mem_rd_op;
        ld_off_r <= ex_addr[1:0];
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a transaction-level model is compared against
// the DUT every cycle, and directed vectors pin hand-computed values.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd_op;
  logic [1:0]  wr_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic        lsu_mem_rd;
  logic        lsu_stall;
  logic [31:0] lsu_rdata;
  logic        lsu_rdata_valid;
  logic        exc_load_misaligned;
  logic        exc_store_misaligned;
  logic [31:0] exc_addr;

  int total = 0;
  int bad   = 0;

  lsu_if dbus ();

  lsu dut (
    .clk                  (clk),
    .rst                  (rst),
    .ex_mem_rd_op         (rd_op),
    .ex_mem_wr_op         (wr_op),
    .ex_addr              (addr),
    .ex_wdata             (wdata),
    .flush                (flush),
    .dbus                 (dbus),
    .lsu_mem_rd           (lsu_mem_rd),
    .lsu_stall            (lsu_stall),
    .lsu_rdata            (lsu_rdata),
    .lsu_rdata_valid      (lsu_rdata_valid),
    .exc_load_misaligned  (exc_load_misaligned),
    .exc_store_misaligned (exc_store_misaligned),
    .exc_addr             (exc_addr)
  );

  always #5 clk = ~clk;

  // Model state: is a load outstanding, has it been killed, and how to format it.
  logic       m_busy;
  logic       m_killed;
  logic [2:0] m_op;
  logic [1:0] m_off;

  // Expected outputs for the current cycle.
  logic        e_st, e_ld, e_mis, e_ok, e_req, e_fault, e_we, e_mem_rd, e_valid, e_stall;
  int          e_sz;
  logic [3:0]  e_be;
  logic [31:0] e_wdata, e_rdata, e_sh, e_b;

  // Model: outputs from the access size, the in-flight load and the bus inputs.
  always_comb begin
    e_st = (wr_op != 2'd0);
    e_ld = (rd_op >= 3'd1) && (rd_op <= 3'd5);
    e_sz = 1;
    if (e_st) e_sz = (wr_op == 2'd3) ? 4 : int'(wr_op);
    else if (e_ld) e_sz = (rd_op == 3'd3) ? 4 : ((rd_op == 3'd1 || rd_op == 3'd4) ? 1 : 2);
    e_mis    = (int'(addr[1:0]) % e_sz) != 0;
    e_ok     = !rst && !flush && (!m_busy || (!m_killed && dbus.dbus_rvalid));
    e_req    = e_ok && (e_st || e_ld) && !e_mis;
    e_fault  = e_ok && (e_st || e_ld) && e_mis;
    e_we     = e_req && e_st;
    e_mem_rd = e_req && !e_st && dbus.dbus_ready;
    e_be     = 4'hF;
    if (e_st) e_be = 4'(((32'd1 << e_sz) - 32'd1) << addr[1:0]);
    e_wdata = 32'd0;
    for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = wdata[8*(i % e_sz) +: 8];
    e_valid = !rst && m_busy && !m_killed && dbus.dbus_rvalid && !flush;
    e_stall = !rst && ((m_busy && (m_killed || !dbus.dbus_rvalid)) || (e_req && !dbus.dbus_ready));
    e_sh    = dbus.dbus_rdata >> (8 * int'(m_off));
    e_b     = 32'd0;
    e_rdata = 32'd0;
    if (e_valid) begin
      case (m_op)
        3'd1: begin e_b = e_sh & 32'hFF;   e_rdata = (e_b >= 32'd128)   ? e_b - 32'd256   : e_b; end
        3'd4: begin e_b = e_sh & 32'hFF;   e_rdata = e_b; end
        3'd2: begin e_b = e_sh & 32'hFFFF; e_rdata = (e_b >= 32'd32768) ? e_b - 32'd65536 : e_b; end
        3'd5: begin e_b = e_sh & 32'hFFFF; e_rdata = e_b; end
        3'd3: e_rdata = dbus.dbus_rdata;
        default: e_rdata = 32'd0;
      endcase
    end
  end

  // Model update: a load completes on rvalid, is killed by flush, or starts on acceptance.
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_killed <= 1'b0; m_op <= 3'd0; m_off <= 2'd0;
    end else begin
      if (m_busy && dbus.dbus_rvalid) begin
        m_busy <= 1'b0; m_killed <= 1'b0;
      end else if (m_busy && flush) begin
        m_killed <= 1'b1;
      end
      if (e_mem_rd) begin
        m_busy <= 1'b1; m_killed <= 1'b0; m_op <= rd_op; m_off <= addr[1:0];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("m_req",    32'(dbus.dbus_req),        32'(e_req));
    check("m_stall",  32'(lsu_stall),            32'(e_stall));
    check("m_memrd",  32'(lsu_mem_rd),           32'(e_mem_rd));
    check("m_valid",  32'(lsu_rdata_valid),      32'(e_valid));
    check("m_rdata",  lsu_rdata,                 e_rdata);
    check("m_excld",  32'(exc_load_misaligned),  32'(e_fault && !e_st));
    check("m_excst",  32'(exc_store_misaligned), 32'(e_fault && e_st));
    if (rst) begin
      check("m_rst_we",    32'(dbus.dbus_we), 32'd0);
      check("m_rst_addr",  dbus.dbus_addr,    32'd0);
      check("m_rst_be",    32'(dbus.dbus_be), 32'd0);
      check("m_rst_wdata", dbus.dbus_wdata,   32'd0);
      check("m_rst_excad", exc_addr,          32'd0);
    end else begin
      if (e_req) begin
        check("m_we",   32'(dbus.dbus_we), 32'(e_we));
        check("m_addr", dbus.dbus_addr,    addr & 32'hFFFF_FFFC);
        check("m_be",   32'(dbus.dbus_be), 32'(e_be));
      end
      if (e_we) check("m_wdata", dbus.dbus_wdata, e_wdata);
      if (e_fault) check("m_excaddr", exc_addr, addr);
    end
  end

  // Apply one cycle of stimulus just after the edge; return at the sampling point.
  task automatic step(input logic rs, input logic [2:0] r, input logic [1:0] w,
                      input logic [31:0] a, input logic [31:0] wd, input logic fl,
                      input logic rdy, input logic rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    rst = rs; rd_op = r; wr_op = w; addr = a; wdata = wd; flush = fl;
    dbus.dbus_ready = rdy; dbus.dbus_rvalid = rv; dbus.dbus_rdata = rd;
    @(negedge clk);
  endtask

  logic [2:0]  lops  [5] = '{3'd1, 3'd4, 3'd2, 3'd5, 3'd3};
  logic [31:0] laddr [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100};
  logic [31:0] lexp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h00007F01, 32'h80F17F01};
  int cnt_stall, cnt_mrd, cnt_valid;

  initial begin
    rst = 1'b1; rd_op = 3'd0; wr_op = 2'd0; addr = 32'd0; wdata = 32'd0; flush = 1'b0;
    dbus.dbus_ready = 1'b0; dbus.dbus_rvalid = 1'b0; dbus.dbus_rdata = 32'd0;

    // Reset with a load presented: everything stays 0.
    step(1'b1, 3'd3, 2'd0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    check("rst_req", 32'(dbus.dbus_req), 32'd0);
    step(1'b1, 3'd3, 2'd0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    check("rst_memrd", 32'(lsu_mem_rd), 32'd0);
    step(1'b0, 3'd0, 2'd0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    check("post_rst_valid", 32'(lsu_rdata_valid), 32'd0);

    // Stores.
    step(1'b0, 3'd0, 2'd1, 32'h1003, 32'h0000_00AB, 1'b0, 1'b1, 1'b0, 32'd0);
    check("sb_req", 32'(dbus.dbus_req), 32'd1);
    check("sb_we", 32'(dbus.dbus_we), 32'd1);
    check("sb_addr", dbus.dbus_addr, 32'h1000);
    check("sb_be", 32'(dbus.dbus_be), 32'h8);
    check("sb_wdata", dbus.dbus_wdata, 32'hABAB_ABAB);
    check("sb_stall", 32'(lsu_stall), 32'd0);
    step(1'b0, 3'd0, 2'd2, 32'h1002, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 32'd0);
    check("sh_be", 32'(dbus.dbus_be), 32'hC);
    check("sh_wdata", dbus.dbus_wdata, 32'h1234_1234);

    // Load formatting: accept, one wait cycle, then data.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, lops[i], 2'd0, laddr[i], 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
      check("ld_memrd", 32'(lsu_mem_rd), 32'd1);
      check("ld_acc_stall", 32'(lsu_stall), 32'd0);
      step(1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
      check("ld_wait_stall", 32'(lsu_stall), 32'd1);
      step(1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h80F1_7F01);
      check("ld_valid", 32'(lsu_rdata_valid), 32'd1);
      check("ld_rdata", lsu_rdata, lexp[i]);
      check("ld_done_stall", 32'(lsu_stall), 32'd0);
    end

    // Wait states: two not-ready cycles, then three cycles before rvalid.
    cnt_stall = 0; cnt_mrd = 0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 3'd3, 2'd0, 32'h200, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      check("ws_req", 32'(dbus.dbus_req), 32'd1);
      cnt_stall += int'(lsu_stall); cnt_mrd += int'(lsu_mem_rd);
    end
    step(1'b0, 3'd3, 2'd0, 32'h200, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    cnt_stall += int'(lsu_stall); cnt_mrd += int'(lsu_mem_rd);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
      cnt_stall += int'(lsu_stall); cnt_mrd += int'(lsu_mem_rd);
    end
    step(1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'hCAFE_0001);
    cnt_stall += int'(lsu_stall); cnt_mrd += int'(lsu_mem_rd);
    check("ws_rdata", lsu_rdata, 32'hCAFE_0001);
    check("ws_stall_cnt", 32'(cnt_stall), 32'd5);
    check("ws_memrd_cnt", 32'(cnt_mrd), 32'd1);

    // Misaligned accesses.
    step(1'b0, 3'd3, 2'd0, 32'h2002, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    check("mis_lw_exc", 32'(exc_load_misaligned), 32'd1);
    check("mis_lw_addr", exc_addr, 32'h2002);
    check("mis_lw_req", 32'(dbus.dbus_req), 32'd0);
    check("mis_lw_stall", 32'(lsu_stall), 32'd0);
    step(1'b0, 3'd0, 2'd2, 32'h2001, 32'h55, 1'b0, 1'b1, 1'b0, 32'd0);
    check("mis_sh_exc", 32'(exc_store_misaligned), 32'd1);
    check("mis_sh_addr", exc_addr, 32'h2001);
    step(1'b0, 3'd5, 2'd0, 32'h2003, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);

    // Flush of an in-flight load: drained without a result.
    cnt_stall = 0; cnt_valid = 0;
    step(1'b0, 3'd3, 2'd0, 32'h400, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0);
    cnt_stall += int'(lsu_stall); cnt_valid += int'(lsu_rdata_valid);
    step(1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    cnt_stall += int'(lsu_stall); cnt_valid += int'(lsu_rdata_valid);
    step(1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1234_5678);
    cnt_stall += int'(lsu_stall); cnt_valid += int'(lsu_rdata_valid);
    step(1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    check("fl_idle_stall", 32'(lsu_stall), 32'd0);
    check("fl_stall_cnt", 32'(cnt_stall), 32'd3);
    check("fl_valid_cnt", 32'(cnt_valid), 32'd0);

    // Flush coincident with rvalid: result dropped, nothing issued.
    step(1'b0, 3'd3, 2'd0, 32'h500, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 3'd3, 2'd0, 32'h504, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0BAD_0BAD);
    check("flrv_valid", 32'(lsu_rdata_valid), 32'd0);
    check("flrv_req", 32'(dbus.dbus_req), 32'd0);
    step(1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    check("flrv_stall", 32'(lsu_stall), 32'd0);

    // Back-to-back: LW then SW issued in the rvalid cycle; then LW then LBU.
    step(1'b0, 3'd3, 2'd0, 32'h3000, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 3'd0, 2'd3, 32'h3000, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 32'h1122_3344);
    check("b2b_valid", 32'(lsu_rdata_valid), 32'd1);
    check("b2b_rdata", lsu_rdata, 32'h1122_3344);
    check("b2b_req", 32'(dbus.dbus_req), 32'd1);
    check("b2b_we", 32'(dbus.dbus_we), 32'd1);
    check("b2b_stall", 32'(lsu_stall), 32'd0);
    step(1'b0, 3'd3, 2'd0, 32'h3004, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 3'd4, 2'd0, 32'h3001, 32'd0, 1'b0, 1'b1, 1'b1, 32'h5566_7788);
    check("b2b_ld_memrd", 32'(lsu_mem_rd), 32'd1);
    step(1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_AB00);
    check("b2b_lbu", lsu_rdata, 32'h0000_00AB);

    // Flush in IDLE suppresses both request and exception.
    step(1'b0, 3'd3, 2'd0, 32'h600, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0);
    check("flidle_req", 32'(dbus.dbus_req), 32'd0);
    step(1'b0, 3'd3, 2'd0, 32'h602, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0);
    check("flidle_exc", 32'(exc_load_misaligned), 32'd0);

    // Reset while waiting for read data; a late rvalid is ignored.
    step(1'b0, 3'd3, 2'd0, 32'h700, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b1, 3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    check("rstw_stall", 32'(lsu_stall), 32'd0);
    step(1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    check("rstw_valid", 32'(lsu_rdata_valid), 32'd0);
    check("rstw_rdata", lsu_rdata, 32'd0);
    check("rstw_stall2", 32'(lsu_stall), 32'd0);

    step(1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
